// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, FSM state encoding and constants shared by the
//               registered multi-cycle EX-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_XOR   = 4'b1001;
  localparam logic [3:0] OP_NOR   = 4'b1010;
  localparam logic [3:0] OP_ILL   = 4'b1011;
  localparam logic [3:0] OP_MUL   = 4'b1100;
  localparam logic [3:0] OP_MULHU = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_REMU  = 4'b1111;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_MUL  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DIV  = 2'd2;

  // Fill bit replicated to the datapath width for the illegal-opcode result.
  localparam logic ILLEGAL_RESULT_BIT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/alu_iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_muldiv
// Description : Iterative shift-add multiplier / restoring divider, one bit
//               per cycle over a 2W-bit working register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         div_mode,
  input  logic         sel_hi,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CNT_W = $clog2(W) + 1;

  logic [2*W-1:0] acc_q, acc_d, acc_step;
  logic [W-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           div_q, div_d, hi_q, hi_d;
  logic [W:0]     partial;

  // Divide keeps remainder:quotient in acc; multiply keeps partial:multiplier.
  always_comb begin
    acc_step = acc_q;
    partial  = '0;
    if (div_q) begin
      partial = acc_q[2*W-1:W-1] - {1'b0, opb_q};
      if (!partial[W]) acc_step = {partial[W-1:0], acc_q[W-2:0], 1'b1};
      else             acc_step = {acc_q[2*W-2:0], 1'b0};
    end else begin
      partial  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
      acc_step = {partial, acc_q[W-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    div_d = div_q;
    hi_d  = hi_q;
    if (start) begin
      acc_d = {{W{1'b0}}, (div_mode ? op_a : op_b)};
      opb_d = div_mode ? op_b : op_a;
      cnt_d = CNT_W'(W);
      div_d = div_mode;
      hi_d  = sel_hi;
    end else if (busy) begin
      acc_d = acc_step;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      hi_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      hi_q  <= hi_d;
    end
  end

  // The result is taken from the final step so it can be registered that edge.
  assign busy   = (cnt_q != '0);
  assign done   = (cnt_q == CNT_W'(1));
  assign result = hi_q ? acc_step[2*W-1:W] : acc_step[W-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Registered EX-stage ALU with valid/ready handshakes; single
//               cycle logic/arith/shift ops, iterative MUL/DIV engine.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_pkg::*;
#(
  parameter int ANCHO_BUS = 32,
  parameter int SHAMT_W   = $clog2(ANCHO_BUS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ANCHO_BUS-1:0] data1,
  input  logic [ANCHO_BUS-1:0] data2,
  input  logic [3:0]           operation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ANCHO_BUS-1:0] alu_result,
  output logic                 zero,
  output logic                 negative,
  output logic                 overflow,
  output logic                 div_zero,
  output logic                 illegal
);

  logic [STATE_W-1:0]   state_q, state_d;
  logic                 accept, start, is_mul, is_div, div_by_zero;
  logic                 eng_busy, eng_done;
  logic [ANCHO_BUS-1:0] eng_result;
  logic [ANCHO_BUS-1:0] sum, diff, comb_result, new_result;
  logic [SHAMT_W-1:0]   shamt;
  logic                 comb_ovf, comb_ill, load, new_ovf, new_dz, new_ill;
  logic                 out_valid_q, out_valid_d, zero_q, zero_d, negative_q, negative_d;
  logic                 overflow_q, overflow_d, div_zero_q, div_zero_d, illegal_q, illegal_d;
  logic [ANCHO_BUS-1:0] result_q, result_d;

  assign is_mul      = (operation == OP_MUL) || (operation == OP_MULHU);
  assign is_div      = (operation == OP_DIVU) || (operation == OP_REMU);
  assign div_by_zero = is_div && (data2 == '0);
  assign sum         = data1 + data2;
  assign diff        = data1 - data2;
  assign shamt       = data2[SHAMT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (start) state_d = is_mul ? ST_MUL : ST_DIV;
      ST_MUL, ST_DIV: if (eng_done || !eng_busy) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !rst;
    accept   = in_valid && in_ready;
    start    = accept && (is_mul || (is_div && !div_by_zero));
  end

  alu_iter_muldiv #(.W(ANCHO_BUS)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .div_mode(is_div),
    .sel_hi (operation[0]),
    .op_a   (data1),
    .op_b   (data2),
    .busy   (eng_busy),
    .done   (eng_done),
    .result (eng_result)
  );

  always_comb begin
    comb_result = '0;
    comb_ovf    = 1'b0;
    comb_ill    = 1'b0;
    case (operation)
      OP_AND:  comb_result = data1 & data2;
      OP_OR:   comb_result = data1 | data2;
      OP_XOR:  comb_result = data1 ^ data2;
      OP_NOR:  comb_result = ~(data1 | data2);
      OP_ADD: begin
        comb_result = sum;
        comb_ovf    = (data1[ANCHO_BUS-1] == data2[ANCHO_BUS-1]) && (sum[ANCHO_BUS-1] != data1[ANCHO_BUS-1]);
      end
      OP_SUB: begin
        comb_result = diff;
        comb_ovf    = (data1[ANCHO_BUS-1] != data2[ANCHO_BUS-1]) && (diff[ANCHO_BUS-1] != data1[ANCHO_BUS-1]);
      end
      OP_SLT:  comb_result = {{(ANCHO_BUS-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLTU: comb_result = {{(ANCHO_BUS-1){1'b0}}, (data1 < data2)};
      OP_SLL:  comb_result = data1 << shamt;
      OP_SRL:  comb_result = data1 >> shamt;
      OP_SRA:  comb_result = $signed(data1) >>> shamt;
      OP_DIVU: comb_result = '1;
      OP_REMU: comb_result = data1;
      OP_ILL: begin
        comb_result = {ANCHO_BUS{ILLEGAL_RESULT_BIT}};
        comb_ill    = 1'b1;
      end
      default: comb_result = '0;
    endcase
  end

  // Output register: load a new result, otherwise clear once consumed.
  always_comb begin
    load        = 1'b0;
    new_result  = comb_result;
    new_ovf     = comb_ovf;
    new_dz      = div_by_zero;
    new_ill     = comb_ill;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    div_zero_d  = div_zero_q;
    illegal_d   = illegal_q;
    if (accept && !start) begin
      load = 1'b1;
    end else if (eng_done) begin
      load       = 1'b1;
      new_result = eng_result;
      new_ovf    = 1'b0;
      new_dz     = 1'b0;
      new_ill    = 1'b0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = new_result;
      zero_d      = (new_result == '0);
      negative_d  = new_result[ANCHO_BUS-1];
      overflow_d  = new_ovf;
      div_zero_d  = new_dz;
      illegal_d   = new_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      result_d    = '0;
      zero_d      = 1'b0;
      negative_d  = 1'b0;
      overflow_d  = 1'b0;
      div_zero_d  = 1'b0;
      illegal_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      div_zero_q  <= div_zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign zero       = zero_q;
  assign negative   = negative_q;
  assign overflow   = overflow_q;
  assign div_zero   = div_zero_q;
  assign illegal    = illegal_q;

endmodule
`default_nettype wire
